// File: rtl/fifo_burst_arbiter_pkg.sv
// Shared constants for the FIFO burst arbiter: FSM encoding, default burst length
// and a constant-width helper.
package fifo_burst_arbiter_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] BURST = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam int BURST_LEN_DEF = 8;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_burst_arbiter_if.sv
// Bundle between the burst arbiter, the async FIFO read sides and the SDRAM
// command engine, all in the SDRAM read-clock domain.
interface fifo_burst_arbiter_if
    import fifo_burst_arbiter_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int FIFO_addr_size = 9
);
    localparam int LVL_W = FIFO_addr_size + 1;
    localparam int ID_W  = clog2(NUM_CH);

    // burst_req stays high with burst_ch stable until the single-cycle burst_ack;
    // fifo_r_en is a read strobe already gated by fifo_empty, and rd_vld marks the
    // mux data one cycle after each accepted read.
    logic [NUM_CH-1:0]       fifo_empty;
    logic [NUM_CH*LVL_W-1:0] fifo_level;
    logic [NUM_CH-1:0]       fifo_r_en;
    logic                    burst_req;
    logic [ID_W-1:0]         burst_ch;
    logic                    burst_ack;
    logic                    rd_vld;
    logic                    burst_done;
    logic                    abort;

    modport master (
        input  fifo_empty, fifo_level, burst_ack, abort,
        output fifo_r_en, burst_req, burst_ch, rd_vld, burst_done
    );

    modport slave (
        output fifo_empty, fifo_level, burst_ack, abort,
        input  fifo_r_en, burst_req, burst_ch, rd_vld, burst_done
    );

endinterface

// File: rtl/fifo_burst_arbiter_rr_pick.sv
// Combinational round-robin selector: first eligible channel at or after rr_ptr,
// wrapping modulo NUM_CH.
module rr_pick #(
    parameter int NUM_CH = 2,
    parameter int ID_W   = 1
) (
    input  logic [NUM_CH-1:0] eligible,
    input  logic [ID_W-1:0]   rr_ptr,
    output logic [ID_W-1:0]   grant_id,
    output logic              grant_vld
);

    // Walk offsets from the far end so the closest eligible channel is written last.
    always_comb begin
        int idx;
        grant_id  = rr_ptr;
        grant_vld = 1'b0;
        idx       = 0;
        for (int off = NUM_CH - 1; off >= 0; off--) begin
            idx = (int'(rr_ptr) + off) % NUM_CH;
            if (eligible[idx]) begin
                grant_id  = ID_W'(idx);
                grant_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_burst_arbiter.sv
// Read-side scheduler: picks a FIFO holding a full burst, handshakes the SDRAM
// command engine, then drains exactly BURST_LEN words from that FIFO.
module fifo_burst_arbiter
    import fifo_burst_arbiter_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int FIFO_addr_size = 9,
    parameter int BURST_LEN      = BURST_LEN_DEF
) (
    input  logic                 clk_r,
    input  logic                 rst_r,
    fifo_burst_arbiter_if.master bus,
    output logic [1:0]           state_dbg
);

    localparam int LVL_W = FIFO_addr_size + 1;
    localparam int ID_W  = clog2(NUM_CH);
    localparam int CNT_W = (clog2(BURST_LEN) > 0) ? clog2(BURST_LEN) : 1;

    localparam logic [ID_W-1:0]  LAST_CH   = ID_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [LVL_W-1:0] BURST_LVL = LVL_W'(BURST_LEN);

    logic [1:0]        state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   burst_ch_q;
    logic [ID_W-1:0]   grant_id;
    logic [ID_W-1:0]   next_ptr;
    logic [CNT_W-1:0]  beat_cnt;
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] r_en;
    logic              grant_vld;
    logic              rd_fire;
    logic              rd_vld_q;

    always_comb begin
        eligible = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            eligible[k] = bus.fifo_level[k*LVL_W +: LVL_W] >= BURST_LVL;
        end
    end

    rr_pick #(
        .NUM_CH (NUM_CH),
        .ID_W   (ID_W)
    ) u_rr_pick (
        .eligible  (eligible),
        .rr_ptr    (rr_ptr),
        .grant_id  (grant_id),
        .grant_vld (grant_vld)
    );

    // The empty gate is combinational so a FIFO running dry stalls the burst at once.
    assign rd_fire  = (state == BURST) && !bus.fifo_empty[burst_ch_q];
    assign next_ptr = (burst_ch_q == LAST_CH) ? '0 : burst_ch_q + ID_W'(1);

    always_comb begin
        r_en             = '0;
        r_en[burst_ch_q] = rd_fire;
    end

    always_ff @(posedge clk_r or posedge rst_r) begin
        if (rst_r) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            burst_ch_q <= '0;
            beat_cnt   <= '0;
            rd_vld_q   <= 1'b0;
        end else begin
            rd_vld_q <= rd_fire;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        burst_ch_q <= grant_id;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    // abort wins over a coincident ack; the channel still loses its turn
                    if (bus.abort) begin
                        rr_ptr <= next_ptr;
                        state  <= IDLE;
                    end else if (bus.burst_ack) begin
                        state <= BURST;
                    end
                end
                BURST: begin
                    if (bus.abort) begin
                        rr_ptr   <= next_ptr;
                        beat_cnt <= '0;
                        state    <= IDLE;
                    end else if (rd_fire) begin
                        if (beat_cnt == LAST_BEAT) state <= DONE;
                        else beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    rr_ptr   <= next_ptr;
                    beat_cnt <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.fifo_r_en  = r_en;
    assign bus.burst_req  = (state == REQ);
    assign bus.burst_ch   = burst_ch_q;
    assign bus.rd_vld     = rd_vld_q;
    assign bus.burst_done = (state == DONE);
    assign state_dbg      = state;

endmodule

// File: tb/tb_fifo_burst_arbiter.sv
// Bench for fifo_burst_arbiter: table of grant/abort vectors, directed burst,
// stall and async-reset sequences, and randomized bursts against a round-robin model.
module tb_fifo_burst_arbiter;
    import fifo_burst_arbiter_pkg::*;

    localparam int NUM_CH = 2;
    localparam int FAS    = 9;
    localparam int BLEN   = 8;

    typedef struct {
        int l0;
        int l1;
        bit exp_req;
        int exp_ch;
    } vec_t;

    logic       clk_r = 1'b0;
    logic       rst_r;
    logic [1:0] state_dbg;

    int         checks = 0;
    int         errors = 0;
    logic [0:0] exp_q[$];
    int         model_ptr = 0;
    int         lvl[NUM_CH];

    fifo_burst_arbiter_if #(.NUM_CH(NUM_CH), .FIFO_addr_size(FAS)) bus ();

    fifo_burst_arbiter #(
        .NUM_CH         (NUM_CH),
        .FIFO_addr_size (FAS),
        .BURST_LEN      (BLEN)
    ) dut (
        .clk_r     (clk_r),
        .rst_r     (rst_r),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clk_r = ~clk_r;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_r);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic set_lvl(input int l0, input int l1);
        lvl[0] = l0;
        lvl[1] = l1;
        bus.fifo_level = {10'(l1), 10'(l0)};
    endtask

    // Reference: first channel at or after the pointer holding a whole burst.
    function automatic int rr_expect(input int ptr);
        for (int off = 0; off < NUM_CH; off++) begin
            if (lvl[(ptr + off) % NUM_CH] >= BLEN) return (ptr + off) % NUM_CH;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst_r = 1'b1;
        bus.fifo_empty = '0;
        bus.burst_ack = 1'b0;
        bus.abort = 1'b0;
        set_lvl(0, 0);
        tick();
        rst_r = 1'b0;
        model_ptr = 0;
        exp_q.delete();
    endtask

    task automatic expect_no_req(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("no_req", bus.burst_req, 0);
            chk("no_req_ren", bus.fifo_r_en, 0);
        end
    endtask

    // Called in an IDLE cycle with levels already set so the head of exp_q wins.
    // abort_beat: -1 none, 0 together with ack, >0 after that many accepted reads.
    task automatic run_txn(input int ack_dly, input int stall_at, input int stall_len,
                           input bit rnd, input int abort_beat, input bit keep_lvl);
        int ch, fires, cyc, stalled;
        bit prev_fire, fire, aborted;
        logic [NUM_CH-1:0] exp_ren;
        #1;
        chk("idle_no_req", bus.burst_req, 0);
        if (exp_q.size() == 0) begin
            $display("FAIL exp_q got=empty expected=grant");
            $fatal(1, "expected-grant queue underflow");
        end
        ch = int'(exp_q.pop_front());
        tick();
        chk("req_rise", bus.burst_req, 1);
        chk("grant_ch", bus.burst_ch, ch);
        for (int d = 0; d < ack_dly; d++) begin
            if (rnd) set_lvl($urandom_range(0, 16), $urandom_range(0, 16));
            tick();
            chk("req_hold", bus.burst_req, 1);
            chk("ch_hold", bus.burst_ch, ch);
            chk("req_no_ren", bus.fifo_r_en, 0);
            chk("req_state", state_dbg, REQ);
        end
        bus.burst_ack = 1'b1;
        bus.abort = (abort_beat == 0);
        tick();
        bus.burst_ack = 1'b0;
        bus.abort = 1'b0;
        aborted = (abort_beat == 0);
        fires = 0;
        cyc = 0;
        stalled = 0;
        prev_fire = 1'b0;
        while (!aborted && fires < BLEN && cyc < 200) begin
            cyc++;
            bus.fifo_empty = '0;
            if (rnd) begin
                for (int k = 0; k < NUM_CH; k++) bus.fifo_empty[k] = ($urandom_range(0, 3) == 0);
            end
            if (fires == stall_at && stalled < stall_len) begin
                bus.fifo_empty[ch] = 1'b1;
                stalled++;
            end
            bus.abort = (abort_beat > 0 && fires == abort_beat);
            #1;
            fire = !bus.fifo_empty[ch];
            exp_ren = '0;
            exp_ren[ch] = fire;
            chk("r_en", bus.fifo_r_en, exp_ren);
            chk("rd_vld", bus.rd_vld, prev_fire);
            chk("no_early_done", bus.burst_done, 0);
            chk("burst_no_req", bus.burst_req, 0);
            prev_fire = fire;
            if (fire) fires++;
            aborted = bus.abort;
            tick();
            bus.abort = 1'b0;
        end
        bus.fifo_empty = '0;
        if (!keep_lvl) set_lvl(0, 0);
        #1;
        if (aborted) begin
            chk("abort_no_req", bus.burst_req, 0);
            chk("abort_no_ren", bus.fifo_r_en, 0);
            chk("abort_no_done", bus.burst_done, 0);
            chk("abort_idle", state_dbg, IDLE);
            chk("abort_rd_vld", bus.rd_vld, prev_fire);
        end else begin
            chk("done_pulse", bus.burst_done, 1);
            chk("done_no_ren", bus.fifo_r_en, 0);
            chk("done_no_req", bus.burst_req, 0);
            chk("done_rd_vld", bus.rd_vld, prev_fire);
            tick();
            chk("done_single", bus.burst_done, 0);
            chk("idle_rd_vld", bus.rd_vld, 0);
        end
        model_ptr = (ch + 1) % NUM_CH;
    endtask

    initial begin
        vec_t vecs[10];
        int   e;
        int   r;
        int   ab;

        // Hand-derived from reset (pointer 0); every granted entry is aborted with its ack.
        vecs[0] = '{7,    0,    1'b0, 0};
        vecs[1] = '{8,    0,    1'b1, 0};
        vecs[2] = '{8,    8,    1'b1, 1};
        vecs[3] = '{8,    8,    1'b1, 0};
        vecs[4] = '{0,    7,    1'b0, 0};
        vecs[5] = '{0,    1023, 1'b1, 1};
        vecs[6] = '{1023, 0,    1'b1, 0};
        vecs[7] = '{9,    7,    1'b1, 0};
        vecs[8] = '{0,    0,    1'b0, 0};
        vecs[9] = '{512,  8,    1'b1, 1};

        rst_r = 1'b1;
        bus.fifo_empty = '0;
        bus.burst_ack = 1'b0;
        bus.abort = 1'b0;
        set_lvl(0, 0);
        repeat (2) tick();
        chk("rst_r_en", bus.fifo_r_en, 0);
        chk("rst_req", bus.burst_req, 0);
        chk("rst_ch", bus.burst_ch, 0);
        chk("rst_rd_vld", bus.rd_vld, 0);
        chk("rst_done", bus.burst_done, 0);
        chk("rst_state", state_dbg, IDLE);
        rst_r = 1'b0;

        // Eligibility boundary, round-robin order and abort-with-ack.
        for (int i = 0; i < 10; i++) begin
            set_lvl(vecs[i].l0, vecs[i].l1);
            if (vecs[i].exp_req) begin
                exp_q.push_back(1'(vecs[i].exp_ch));
                run_txn(1, -1, 0, 1'b0, 0, 1'b0);
            end else begin
                expect_no_req(3);
                set_lvl(0, 0);
            end
        end

        // Single ch0 burst, ack three cycles after the request, no stall.
        do_reset();
        set_lvl(8, 0);
        exp_q.push_back(1'b0);
        run_txn(3, -1, 0, 1'b0, -1, 1'b0);

        // Same burst with a three-cycle empty stall after four reads.
        set_lvl(8, 0);
        exp_q.push_back(1'b0);
        run_txn(0, 4, 3, 1'b0, -1, 1'b0);

        // Both channels continuously eligible: grants alternate.
        do_reset();
        set_lvl(20, 20);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        for (int i = 0; i < 4; i++) run_txn(0, -1, 0, 1'b0, -1, (i < 3));

        // Asynchronous reset in the middle of a ch1 burst.
        do_reset();
        set_lvl(8, 0);
        exp_q.push_back(1'b0);
        run_txn(0, -1, 0, 1'b0, -1, 1'b0);
        set_lvl(8, 8);
        tick();
        chk("pre_rst_ch", bus.burst_ch, 1);
        bus.burst_ack = 1'b1;
        tick();
        bus.burst_ack = 1'b0;
        tick();
        tick();
        #2;
        rst_r = 1'b1;
        #1;
        chk("arst_r_en", bus.fifo_r_en, 0);
        chk("arst_req", bus.burst_req, 0);
        chk("arst_ch", bus.burst_ch, 0);
        chk("arst_rd_vld", bus.rd_vld, 0);
        chk("arst_done", bus.burst_done, 0);
        chk("arst_state", state_dbg, IDLE);
        tick();
        rst_r = 1'b0;
        model_ptr = 0;
        exp_q.push_back(1'b0);
        run_txn(0, -1, 0, 1'b0, -1, 1'b0);

        // Randomized levels, ack delays, stalls and aborts against the model.
        do_reset();
        for (int it = 0; it < 80; it++) begin
            set_lvl($urandom_range(0, 16), $urandom_range(0, 16));
            e = rr_expect(model_ptr);
            if (e < 0) begin
                expect_no_req(3);
            end else begin
                r = $urandom_range(0, 9);
                ab = (r == 0) ? 0 : (r == 1) ? $urandom_range(1, BLEN - 1) : -1;
                exp_q.push_back(1'(e));
                run_txn($urandom_range(0, 3), -1, 0, 1'b1, ab, 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_burst_arbiter.md
Name: fifo_burst_arbiter

Overview:
- Read-side scheduler for N async FIFOs draining into the SDRAM controller in the 166 MHz read-clock domain.
- Monitors each FIFO's read-side fill level and picks one channel by round-robin once it holds a full burst.
- Handshakes a write-burst request with the SDRAM command engine, then drives that FIFO's r_en for exactly BURST_LEN accepted words.

Parameters:
- NUM_CH, 2, number of FIFO channels arbitrated (2..4).
- FIFO_addr_size, 9, FIFO address width; level inputs are FIFO_addr_size+1 bits wide.
- BURST_LEN, 8, words per SDRAM burst (power of two, at most 2**FIFO_addr_size).

Ports:
- clk_r  in  1  read-domain clock (SDRAM clock).
- rst_r  in  1  asynchronous, active-high reset.
- fifo_empty  in  NUM_CH  per-channel empty flag from each FIFO read side.
- fifo_level  in  NUM_CH*(FIFO_addr_size+1)  packed per-channel read-side word count; channel k occupies bits [k*(FIFO_addr_size+1) +: FIFO_addr_size+1].
- fifo_r_en  out  NUM_CH  one-hot read enable to the FIFOs.
- burst_req  out  1  burst request to the SDRAM command engine.
- burst_ch  out  clog2(NUM_CH)  channel id of the current request or burst.
- burst_ack  in  1  SDRAM engine accepted the request (single-cycle pulse).
- rd_vld  out  1  FIFO read data on the shared mux is valid this cycle.
- burst_done  out  1  single-cycle pulse after the last word of a burst is read.
- abort  in  1  synchronous abort of the current burst.

Behaviour:
- Reset values: fifo_r_en=0, burst_req=0, burst_ch=0, rd_vld=0, burst_done=0. State=IDLE, rr_ptr=0, beat_cnt=0.
- Eligibility: channel k is eligible when fifo_level[k] >= BURST_LEN. The comparison is unsigned at FIFO_addr_size+1 bits.
- Round-robin: search starts at rr_ptr and wraps modulo NUM_CH. The first eligible channel wins.
- IDLE:
  - If any channel is eligible, latch the winner into burst_ch and go to REQ.
  - burst_req asserts on the next cycle, i.e. one cycle after eligibility is seen.
- REQ:
  - burst_req is held high and burst_ch is held stable until burst_ack.
  - On burst_ack: burst_req falls in the next cycle and the state moves to BURST.
  - burst_ack seen outside REQ is ignored.
- BURST:
  - fifo_r_en[burst_ch] = ~fifo_empty[burst_ch]. This is combinational from state, so the empty gate is immediate.
  - beat_cnt increments on every cycle where r_en is high and empty is low.
  - If empty asserts mid-burst, r_en is gated low and beat_cnt holds (stall); this is never a protocol error.
  - When beat_cnt reaches BURST_LEN-1 with an accepted read, go to DONE.
- DONE:
  - burst_done is high for exactly one cycle.
  - rr_ptr becomes burst_ch+1 mod NUM_CH, and beat_cnt clears.
  - Next state is IDLE. No back-to-back grant from DONE; minimum 1 idle cycle between bursts.
- rd_vld is the registered value of (|fifo_r_en & ~empty of the selected channel), giving one-cycle latency to match the FIFO's synchronous RAM read.
- Counter width is clog2(BURST_LEN). beat_cnt never exceeds BURST_LEN-1.
- abort in REQ or BURST:
  - Next cycle is IDLE: burst_req=0 and fifo_r_en=0.
  - No burst_done is issued, and rr_ptr still advances past the aborted channel.
  - abort in IDLE or DONE is ignored.
- Simultaneous burst_ack and abort in REQ: abort wins and the state goes to IDLE.
- Level changes during REQ do not affect the latched burst_ch.
- Asynchronous reset mid-burst forces all outputs low immediately. The FIFO pointers are not this block's concern.

Decomposition:
- Shared package holds:
  - state encoding localparams: IDLE=2'd0, REQ=2'd1, BURST=2'd2, DONE=2'd3;
  - a clog2 function;
  - the BURST_LEN default.
- One natural sub-module: rr_pick. It is a combinational round-robin selector taking eligible[NUM_CH] and rr_ptr, and producing grant_id and grant_vld. It is reused by the future SDRAM read-side arbiter.

Test Plan:
- NUM_CH=2, BURST_LEN=8, level0=8, level1=0, ack 3 cycles after req:
  - burst_req high 1 cycle after eligibility, with burst_ch=0;
  - exactly 8 fifo_r_en[0] cycles after ack;
  - rd_vld lags r_en by 1 cycle;
  - one burst_done pulse.
- Both levels at 20 continuously, ack immediate: grants alternate 0,1,0,1 over 4 bursts, with 8 reads each.
- During a ch0 burst, force fifo_empty[0]=1 for 3 cycles after 4 reads:
  - r_en drops for those 3 cycles;
  - the remaining 4 reads complete;
  - burst_done occurs 3 cycles later than in the no-stall case.
- Assert abort together with burst_ack in REQ: no r_en pulses, state returns to IDLE, and the next grant goes to ch1 when it is eligible.
- Assert rst_r asynchronously in the middle of BURST: all outputs go to 0 immediately; after release, the first grant goes to ch0 (rr_ptr=0).
- level0=7 (boundary): no request is raised; raising level0 to 8 produces a request on the next cycle.
